// File: rtl/apb_rr_pkg.sv
// Shared types and constants for the round-robin APB master.
package apb_rr_pkg;

   typedef enum logic [1:0] {StIdle, StSetup, StAccess} apb_state_e;

   localparam int unsigned PROT_W = 3;
   localparam int unsigned AW_DEF = 12;
   localparam int unsigned DW_DEF = 32;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_pick #(
   parameter  int unsigned NREQ = 4,
   localparam int unsigned IW   = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   ptr,
   output logic [NREQ-1:0] grant,
   output logic [IW-1:0]   index,
   output logic            any_grant
);

   localparam logic [IW:0] NREQ_W = (IW + 1)'(NREQ);

   logic [NREQ-1:0] rot;
   logic [IW-1:0]   off;
   logic [IW:0]     sum;
   logic            found;

   always_comb begin
      // Rotating the doubled vector puts requester ptr at bit 0.
      rot   = NREQ'({req, req} >> ptr);
      off   = '0;
      found = 1'b0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (rot[i] && !found) begin
            found = 1'b1;
            off   = IW'(i);
         end
      end
      sum = {1'b0, ptr} + {1'b0, off};
      if (sum >= NREQ_W) begin
         sum = sum - NREQ_W;
      end
      index     = sum[IW-1:0];
      any_grant = |req;
      grant     = '0;
      if (any_grant) begin
         grant[index] = 1'b1;
      end
   end

endmodule

// File: rtl/apb_rr_master.sv
// Round-robin APB master: serves NREQ held commands one at a time on a single APB port.
module apb_rr_master
   import apb_rr_pkg::*;
#(
   parameter  int unsigned NREQ = 4,
   parameter  int unsigned AW   = AW_DEF,
   parameter  int unsigned DW   = DW_DEF,
   localparam int unsigned SW   = DW / 8,
   localparam int unsigned IW   = $clog2(NREQ)
) (
   input  logic                     pclk,
   input  logic                     preset,
   input  logic [NREQ-1:0]          req_valid,
   input  logic [NREQ-1:0]          req_write,
   input  logic [NREQ*AW-1:0]       req_addr,
   input  logic [NREQ*DW-1:0]       req_wdata,
   input  logic [NREQ*SW-1:0]       req_strb,
   input  logic [NREQ*PROT_W-1:0]   req_prot,
   output logic [NREQ-1:0]          req_done,
   output logic [DW-1:0]            rsp_rdata,
   output logic                     rsp_slverr,
   output logic                     busy,
   output logic [IW-1:0]            grant_id,
   output logic                     psel,
   output logic                     penable,
   output logic                     pwrite,
   output logic [AW-1:0]            paddr,
   output logic [DW-1:0]            pwdata,
   output logic [SW-1:0]            pstrb,
   output logic [PROT_W-1:0]        pprot,
   input  logic [DW-1:0]            prdata,
   input  logic                     pready,
   input  logic                     pslverr
);

   apb_state_e        state_q, state_d;
   logic              psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
   logic [AW-1:0]     paddr_q, paddr_d;
   logic [DW-1:0]     pwdata_q, pwdata_d;
   logic [SW-1:0]     pstrb_q, pstrb_d;
   logic [PROT_W-1:0] pprot_q, pprot_d;
   logic [IW-1:0]     grant_q, grant_d, ptr_q, ptr_d;
   logic [NREQ-1:0]   done_q, done_d;
   logic [DW-1:0]     rdata_q, rdata_d;
   logic              slverr_q, slverr_d, busy_q, busy_d;

   logic [NREQ-1:0]   cand, pick_grant;
   logic [IW-1:0]     pick_idx;
   logic              pick_any;
   logic              sel_write;
   logic [AW-1:0]     sel_addr;
   logic [DW-1:0]     sel_wdata;
   logic [SW-1:0]     sel_strb;
   logic [PROT_W-1:0] sel_prot;

   // A requester whose done pulse is out this cycle may already show its next command.
   assign cand = req_valid & ~done_q;

   rr_pick #(
      .NREQ (NREQ)
   ) u_pick (
      .req       (cand),
      .ptr       (ptr_q),
      .grant     (pick_grant),
      .index     (pick_idx),
      .any_grant (pick_any)
   );

   always_comb begin
      sel_write = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      sel_strb  = '0;
      sel_prot  = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (pick_grant[i]) begin
            sel_write = req_write[i];
            sel_addr  = req_addr[i*AW +: AW];
            sel_wdata = req_wdata[i*DW +: DW];
            sel_strb  = req_strb[i*SW +: SW];
            sel_prot  = req_prot[i*PROT_W +: PROT_W];
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      psel_d    = psel_q;
      penable_d = penable_q;
      pwrite_d  = pwrite_q;
      paddr_d   = paddr_q;
      pwdata_d  = pwdata_q;
      pstrb_d   = pstrb_q;
      pprot_d   = pprot_q;
      grant_d   = grant_q;
      ptr_d     = ptr_q;
      done_d    = '0;
      rdata_d   = rdata_q;
      slverr_d  = slverr_q;
      busy_d    = busy_q;
      unique case (state_q)
         StIdle: begin
            if (pick_any) begin
               grant_d  = pick_idx;
               pwrite_d = sel_write;
               paddr_d  = sel_addr;
               pwdata_d = sel_wdata;
               pstrb_d  = sel_strb;
               pprot_d  = sel_prot;
               psel_d   = 1'b1;
               busy_d   = 1'b1;
               state_d  = StSetup;
            end
         end
         StSetup: begin
            penable_d = 1'b1;
            state_d   = StAccess;
         end
         StAccess: begin
            if (pready) begin
               psel_d           = 1'b0;
               penable_d        = 1'b0;
               busy_d           = 1'b0;
               done_d[grant_q]  = 1'b1;
               rdata_d          = prdata;
               slverr_d         = pslverr;
               ptr_d            = (grant_q == IW'(NREQ - 1)) ? '0 : grant_q + 1'b1;
               state_d          = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge pclk) begin
      if (preset) begin
         state_q   <= StIdle;
         psel_q    <= 1'b0;
         penable_q <= 1'b0;
         pwrite_q  <= 1'b0;
         paddr_q   <= '0;
         pwdata_q  <= '0;
         pstrb_q   <= '0;
         pprot_q   <= '0;
         grant_q   <= '0;
         ptr_q     <= '0;
         done_q    <= '0;
         rdata_q   <= '0;
         slverr_q  <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         psel_q    <= psel_d;
         penable_q <= penable_d;
         pwrite_q  <= pwrite_d;
         paddr_q   <= paddr_d;
         pwdata_q  <= pwdata_d;
         pstrb_q   <= pstrb_d;
         pprot_q   <= pprot_d;
         grant_q   <= grant_d;
         ptr_q     <= ptr_d;
         done_q    <= done_d;
         rdata_q   <= rdata_d;
         slverr_q  <= slverr_d;
         busy_q    <= busy_d;
      end
   end

   assign psel       = psel_q;
   assign penable    = penable_q;
   assign pwrite     = pwrite_q;
   assign paddr      = paddr_q;
   assign pwdata     = pwdata_q;
   assign pstrb      = pstrb_q;
   assign pprot      = pprot_q;
   assign grant_id   = grant_q;
   assign req_done   = done_q;
   assign rsp_rdata  = rdata_q;
   assign rsp_slverr = slverr_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_apb_rr_master.sv
// Bench for apb_rr_master: directed scenarios plus random traffic against a transfer-level model.
module tb_apb_rr_master;

   localparam int unsigned NREQ = 4;
   localparam int unsigned AW   = 12;
   localparam int unsigned DW   = 32;
   localparam int unsigned SW   = DW / 8;
   localparam int unsigned IW   = $clog2(NREQ);

   logic                pclk = 1'b0;
   logic                preset;
   logic [NREQ-1:0]     req_valid, req_write, req_done;
   logic [NREQ*AW-1:0]  req_addr;
   logic [NREQ*DW-1:0]  req_wdata;
   logic [NREQ*SW-1:0]  req_strb;
   logic [NREQ*3-1:0]   req_prot;
   logic [DW-1:0]       rsp_rdata, pwdata, prdata;
   logic                rsp_slverr, busy, psel, penable, pwrite, pready, pslverr;
   logic [IW-1:0]       grant_id;
   logic [AW-1:0]       paddr;
   logic [SW-1:0]       pstrb;
   logic [2:0]          pprot;

   always #5 pclk = ~pclk;

   apb_rr_master #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
      .pclk       (pclk),
      .preset     (preset),
      .req_valid  (req_valid),
      .req_write  (req_write),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_strb   (req_strb),
      .req_prot   (req_prot),
      .req_done   (req_done),
      .rsp_rdata  (rsp_rdata),
      .rsp_slverr (rsp_slverr),
      .busy       (busy),
      .grant_id   (grant_id),
      .psel       (psel),
      .penable    (penable),
      .pwrite     (pwrite),
      .paddr      (paddr),
      .pwdata     (pwdata),
      .pstrb      (pstrb),
      .pprot      (pprot),
      .prdata     (prdata),
      .pready     (pready),
      .pslverr    (pslverr)
   );

   int checks = 0;
   int errors = 0;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Transfer-level reference: which command is on the bus and how far it has got.
   int              m_phase = 0;  // 0 no transfer, 1 first bus cycle, 2 data phase
   int              m_ptr = 0;
   int              m_gid = 0;
   logic            m_write = 1'b0;
   logic [AW-1:0]   m_addr = '0;
   logic [DW-1:0]   m_wdata = '0;
   logic [SW-1:0]   m_strb = '0;
   logic [2:0]      m_prot = '0;
   logic [NREQ-1:0] m_done = '0;
   logic [DW-1:0]   m_rdata = '0;
   logic            m_slverr = 1'b0;

   function automatic void model_next();
      logic [NREQ-1:0] cand;
      int              j;
      if (preset) begin
         m_phase = 0; m_ptr = 0; m_gid = 0; m_write = 1'b0; m_addr = '0; m_wdata = '0;
         m_strb = '0; m_prot = '0; m_done = '0; m_rdata = '0; m_slverr = 1'b0;
      end else begin
         cand   = req_valid & ~m_done;
         m_done = '0;
         if (m_phase == 0) begin
            for (int k = 0; k < NREQ; k++) begin
               j = (m_ptr + k) % NREQ;
               if (cand[j]) begin
                  m_gid   = j;
                  m_write = req_write[j];
                  m_addr  = req_addr[j*AW +: AW];
                  m_wdata = req_wdata[j*DW +: DW];
                  m_strb  = req_strb[j*SW +: SW];
                  m_prot  = req_prot[j*3 +: 3];
                  m_phase = 1;
                  break;
               end
            end
         end else if (m_phase == 1) begin
            m_phase = 2;
         end else if (pready) begin
            m_done[m_gid] = 1'b1;
            m_rdata       = prdata;
            m_slverr      = pslverr;
            m_ptr         = (m_gid + 1) % NREQ;
            m_phase       = 0;
         end
      end
   endfunction

   task automatic compare();
      check_eq("psel", psel, m_phase != 0);
      check_eq("penable", penable, m_phase == 2);
      check_eq("busy", busy, m_phase != 0);
      check_eq("pwrite", pwrite, m_write);
      check_eq("paddr", paddr, m_addr);
      check_eq("pwdata", pwdata, m_wdata);
      check_eq("pstrb", pstrb, m_strb);
      check_eq("pprot", pprot, m_prot);
      check_eq("grant_id", grant_id, m_gid);
      check_eq("req_done", req_done, m_done);
      check_eq("rsp_rdata", rsp_rdata, m_rdata);
      check_eq("rsp_slverr", rsp_slverr, m_slverr);
   endtask

   task automatic cycle();
      model_next();
      @(posedge pclk);
      #1;
      compare();
   endtask

   task automatic set_cmd(input int i, input logic w, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [SW-1:0] s, input logic [2:0] p);
      req_write[i]          = w;
      req_addr[i*AW +: AW]  = a;
      req_wdata[i*DW +: DW] = d;
      req_strb[i*SW +: SW]  = s;
      req_prot[i*3 +: 3]    = p;
      req_valid[i]          = 1'b1;
   endtask

   task automatic new_cmd(input int i);
      set_cmd(i, 1'($urandom), AW'($urandom), $urandom, SW'($urandom), 3'($urandom));
   endtask

   task automatic run_to_done(input string tag, input int budget, output int n);
      n = 0;
      do begin
         cycle();
         n++;
      end while (req_done == '0 && n < budget);
      check_eq({tag, "_done_seen"}, 64'(req_done != '0), 64'd1);
   endtask

   task automatic do_reset();
      preset    = 1'b1;
      req_valid = '0;
      cycle();
      preset    = 1'b0;
   endtask

   int n, ndone, last;
   int exp_order[5] = '{0, 1, 2, 3, 0};

   initial begin
      req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0; req_strb = '0;
      req_prot = '0; prdata = '0; pready = 1'b0; pslverr = 1'b0;
      do_reset();
      check_eq("rst_psel", psel, 1'b0);
      check_eq("rst_done", req_done, '0);

      // Single read on requester 2; pready already high in IDLE/SETUP.
      pready = 1'b1; prdata = 32'hDEADBEEF;
      set_cmd(2, 1'b0, 12'h123, 32'h0, 4'h0, 3'h0);
      cycle(); check_eq("rd_setup", {psel, penable}, 2'b10);
      cycle(); check_eq("rd_access", {psel, penable}, 2'b11);
      cycle();
      check_eq("rd_done", req_done, 4'b0100);
      check_eq("rd_data", rsp_rdata, 32'hDEADBEEF);
      check_eq("rd_err", rsp_slverr, 1'b0);
      req_valid[2] = 1'b0;
      cycle();

      // Write on requester 0 with three wait states.
      pready = 1'b0;
      set_cmd(0, 1'b1, 12'h0A4, 32'hA5A5_0001, 4'b0011, 3'b010);
      for (int k = 1; k <= 5; k++) begin
         cycle();
         check_eq("wr_psel", psel, 1'b1);
         check_eq("wr_addr", paddr, 12'h0A4);
         check_eq("wr_data", pwdata, 32'hA5A5_0001);
         check_eq("wr_strb", pstrb, 4'b0011);
         check_eq("wr_done_early", req_done, '0);
      end
      pready = 1'b1;
      cycle();
      check_eq("wr_done", req_done, 4'b0001);
      check_eq("wr_psel_low", psel, 1'b0);
      req_valid[0] = 1'b0;
      cycle();

      // All four requesting continuously from reset.
      do_reset();
      for (int i = 0; i < NREQ; i++) new_cmd(i);
      ndone = 0; last = 0; n = 0;
      while (ndone < 5 && n < 40) begin
         prdata = $urandom;
         cycle();
         n++;
         if (req_done != '0) begin
            check_eq($sformatf("rr_order%0d", ndone), 64'(grant_id), 64'(exp_order[ndone]));
            check_eq($sformatf("rr_gap%0d", ndone), 64'(n - last), 64'd3);
            last = n;
            ndone++;
            for (int i = 0; i < NREQ; i++) if (m_done[i]) new_cmd(i);
         end
      end
      check_eq("rr_count", 64'(ndone), 64'd5);
      req_valid = '0;
      cycle();

      // Error response on requester 2, then a clean one.
      pslverr = 1'b1;
      new_cmd(2);
      run_to_done("err", 20, n);
      check_eq("err_slverr", rsp_slverr, 1'b1);
      check_eq("err_done", req_done, 4'b0100);
      req_valid[2] = 1'b0; pslverr = 1'b0;
      cycle();
      new_cmd(2);
      run_to_done("ok", 20, n);
      check_eq("ok_slverr", rsp_slverr, 1'b0);
      req_valid[2] = 1'b0;
      cycle();

      // Serve 1 alone to leave the pointer at 2, then race 1 against 3.
      new_cmd(1);
      run_to_done("pre", 20, n);
      req_valid[1] = 1'b0;
      cycle();
      new_cmd(1); new_cmd(3);
      run_to_done("pri_first", 20, n);
      check_eq("pri_first_id", grant_id, 2'd3);
      check_eq("pri_latency", 64'(n), 64'd3);
      req_valid[3] = 1'b0;
      run_to_done("pri_second", 20, n);
      check_eq("pri_second_id", grant_id, 2'd1);
      req_valid[1] = 1'b0;
      cycle();

      // Reset during a wait state.
      pready = 1'b0;
      new_cmd(1);
      for (int k = 0; k < 3; k++) cycle();
      preset = 1'b1;
      req_valid = '0;
      cycle();
      check_eq("rstacc_psel", psel, 1'b0);
      check_eq("rstacc_done", req_done, '0);
      preset = 1'b0;
      new_cmd(0); new_cmd(2);
      cycle();
      check_eq("rstacc_grant", grant_id, 2'd0);
      check_eq("rstacc_setup", psel, 1'b1);
      pready = 1'b1;
      run_to_done("rstacc_a", 20, n);
      req_valid[0] = 1'b0;
      run_to_done("rstacc_b", 20, n);
      check_eq("rstacc_b_id", grant_id, 2'd2);
      req_valid[2] = 1'b0;
      cycle();

      // Random traffic, withdrawals, stray ready, errors and occasional resets.
      for (int c = 0; c < 4000; c++) begin
         pready  = ($urandom % 3) != 0;
         pslverr = ($urandom % 5) == 0;
         prdata  = $urandom;
         preset  = ($urandom % 300) == 0;
         cycle();
         preset = 1'b0;
         for (int i = 0; i < NREQ; i++) begin
            if (m_done[i]) begin
               if ($urandom % 2) new_cmd(i);
               else req_valid[i] = 1'b0;
            end else if (!req_valid[i]) begin
               if ($urandom % 4 == 0) new_cmd(i);
            end else if (!(m_phase != 0 && m_gid == i) && ($urandom % 40 == 0)) begin
               req_valid[i] = 1'b0;
            end
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/apb_rr_master.md
# apb_rr_master

Round-robin APB master that shares one APB completer port (e.g. the a-side of the APB clock-domain bridge) among NREQ local requesters.
- Each requester presents a held command; the block grants one at a time and runs a full APB3/APB4 SETUP/ACCESS transfer with wait states.
- It returns read data and error to the granted requester with a one-cycle done pulse.
- It sits in the pclk domain, in front of the bridge or any APB completer.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..8)
- AW, 12, address width
- DW, 32, data width (strobe width DW/8)

Ports:
- pclk  in  1  the block's one clock
- preset  in  1  synchronous, active-high reset
- req_valid  in  NREQ  request pending, one bit per requester
- req_write  in  NREQ  1 = write
- req_addr  in  NREQ*AW  requester i at bits [i*AW +: AW]
- req_wdata  in  NREQ*DW  requester i at [i*DW +: DW]
- req_strb  in  NREQ*DW/8  requester i at [i*DW/8 +: DW/8]
- req_prot  in  NREQ*3  requester i at [i*3 +: 3]
- req_done  out  NREQ  one-cycle completion pulse, one-hot
- rsp_rdata  out  DW  read data, valid while any req_done bit is high
- rsp_slverr  out  1  pslverr of the completed transfer, valid with req_done
- busy  out  1  high in SETUP and ACCESS
- grant_id  out  $clog2(NREQ)  index of the current or last granted requester
- psel, penable, pwrite  out  1  APB control
- paddr  out  AW  APB address
- pwdata  out  DW  APB write data
- pstrb  out  DW/8  APB write strobe
- pprot  out  3  APB protection
- prdata  in  DW  APB read data
- pready  in  1  APB ready
- pslverr  in  1  APB error

## Operation
- Requester protocol:
  - Assert req_valid[i] with its fields stable.
  - Hold both until req_done[i].
  - req_valid[i] may stay high in the done cycle only if a new command is presented, but it is not re-granted in that cycle.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - Candidates = req_valid & ~req_done.
  - If any candidate exists, the first one at or after rr_ptr (cyclic search upward, wrapping NREQ-1 -> 0) wins.
  - On a win: grant_id <= index; paddr, pwrite, pwdata, pstrb, pprot are loaded from that slice; psel <= 1; state goes to SETUP.
  - If there is no candidate, stay in IDLE.
- SETUP: one cycle with psel=1, penable=0. Then penable <= 1 and state goes to ACCESS.
- ACCESS:
  - psel=1, penable=1.
  - pready is sampled only in this state; pready in IDLE or SETUP is ignored.
  - pready=0: hold all APB outputs unchanged (wait state, no limit).
  - pready=1: psel <= 0, penable <= 0, req_done[grant_id] <= 1, rsp_rdata <= prdata, rsp_slverr <= pslverr, rr_ptr <= grant_id+1 (mod NREQ), state goes to IDLE.
- rsp_rdata is captured for writes too. Its content is meaningless for writes.
- pslverr is passed through only; the block does not retry.
- Simultaneous requests: the one nearest rr_ptr wins. A requester that stays high is served again only after every other pending requester has been served once.
- req_valid dropped before its grant: the request is withdrawn and no transfer occurs.

## Timing
- Reset values:
  - psel, penable, pwrite, req_done, rsp_slverr, busy: 0
  - paddr, pwdata, pstrb, pprot, rsp_rdata: 0
  - grant_id = 0, rr_ptr = 0, state = IDLE
- Reset mid-transfer:
  - psel and penable are 0 after the reset edge.
  - No req_done pulse is issued for the aborted transfer.
  - rr_ptr returns to 0.
- Latency:
  - req_valid seen in IDLE at cycle t: SETUP at t+1, ACCESS at t+2.
  - With pready=1 at t+2: req_done and rsp data at t+3, psel low at t+3.
  - Each wait state adds one cycle.
- Back-to-back:
  - IDLE at t+3 may grant the next requester, so its SETUP is at t+4.
  - Minimum period is 3 cycles per transfer.
- All outputs are registered. There is no combinational path from pready or req_valid to any output.

## Structure
- Package apb_rr_pkg:
  - state enum {IDLE, SETUP, ACCESS}
  - PROT_W = 3
  - default AW = 12 and DW = 32
- Sub-module rr_pick:
  - Inputs: NREQ request vector, pointer.
  - Outputs: one-hot grant, binary index, any_grant.
  - Purely combinational, using a doubled-vector rotate.
- Top level: FSM, APB output registers, response registers, rr_ptr.

## Test plan
- Single read, NREQ=4:
  - Stimulus: req_valid=4'b0100, addr 0x123, pready=1 in first ACCESS, prdata=0xDEADBEEF.
  - Required: SETUP then ACCESS; req_done=4'b0100 at t+3; rsp_rdata=0xDEADBEEF; rsp_slverr=0.
- Write with 3 wait states:
  - Stimulus: req 0, wdata 0xA5A5_0001, strb 4'b0011, pready low for 3 ACCESS cycles.
  - Required: psel=1 for 5 cycles; all APB outputs stable; done at t+6.
- All four requesting continuously from reset:
  - Required: grant order 0,1,2,3,0; one done per 3 cycles; no requester is served twice in a row.
- Error response:
  - Stimulus: pslverr=1 with pready on req 2.
  - Required: rsp_slverr=1 with req_done[2]; the next transfer shows rsp_slverr=0.
- Priority and stray ready:
  - Stimulus: req 1 and req 3 valid, rr_ptr=2.
  - Required: 3 granted first, then 1.
  - Stimulus: pready=1 held during IDLE and SETUP.
  - Required: no early completion.
- Reset in ACCESS:
  - Stimulus: preset=1 for 1 cycle during a wait state.
  - Required: psel=0 next cycle; no req_done; next grant starts from requester 0.
